// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide controller.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } mdState_e;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DIV_ITERS = 32;

  // Divide-by-zero: quotient reads all ones, remainder echoes the dividend.
  localparam logic [DATA_W-1:0] DIVZ_LO = 32'hFFFF_FFFF;

  // Magnitude of a value, treated as two's complement only when isSigned is set.
  function automatic logic [DATA_W-1:0] absVal(input logic [DATA_W-1:0] v, input logic isSigned);
    return (isSigned && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring radix-2 divider on operand magnitudes, with sign fix on the result.
module md_div_core
  import md_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              signedOp,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient_c,
  output logic [DATA_W-1:0] remainder_c
);

  logic [DATA_W-1:0] remQ, quoQ, divQ;
  logic              negQuoQ, negRemQ;

  logic [DATA_W:0]   remShift;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] remNext, quoNext;

  // One step: shift the next dividend bit into the remainder and try to subtract.
  assign remShift = {remQ, quoQ[DATA_W-1]};
  assign trial    = remShift - {1'b0, divQ};
  assign remNext  = trial[DATA_W] ? remShift[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quoNext  = {quoQ[DATA_W-2:0], ~trial[DATA_W]};

  // Results reflect the step in flight so the final step can be captured directly.
  assign quotient_c  = negQuoQ ? DATA_W'(-quoNext) : quoNext;
  assign remainder_c = negRemQ ? DATA_W'(-remNext) : remNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      remQ    <= '0;
      quoQ    <= '0;
      divQ    <= '0;
      negQuoQ <= 1'b0;
      negRemQ <= 1'b0;
    end else if (load) begin
      remQ    <= '0;
      quoQ    <= absVal(dividend, signedOp);
      divQ    <= absVal(divisor, signedOp);
      negQuoQ <= signedOp & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      negRemQ <= signedOp & dividend[DATA_W-1];
    end else if (step) begin
      remQ <= remNext;
      quoQ <= quoNext;
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// Execute-stage multiply/divide controller: FSM, single-cycle multiply, HI/LO result registers.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned DIV_ITERS = md_pkg::DIV_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic        is_divE,
  input  logic        signedE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        cancelE,
  output logic        stall_mdE,
  output logic        md_doneE,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(DIV_ITERS + 1);

  mdState_e          state;
  logic [CNT_W-1:0]  cnt;
  logic [63:0]       product_c;
  logic              goE_c, divLoad_c, divStep_c, lastStep_c;
  logic [DATA_W-1:0] quotient_c, remainder_c;

  assign goE_c      = startE & ~cancelE;
  assign divLoad_c  = (state == IDLE) & goE_c & is_divE & (srcbE != '0);
  assign divStep_c  = (state == DIV) & ~cancelE;
  assign lastStep_c = (cnt == CNT_W'(DIV_ITERS - 1));

  assign product_c = {{32{signedE & srcaE[31]}}, srcaE} * {{32{signedE & srcbE[31]}}, srcbE};

  // Stall must respond in the issuing cycle, so it is decoded from state and live inputs.
  always_comb begin
    stall_mdE = 1'b0;
    md_doneE  = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:    stall_mdE = goE_c;
        DIV:     stall_mdE = ~cancelE;
        DONE:    md_doneE  = ~cancelE;
        default: ;
      endcase
    end
  end

  md_div_core u_div (
    .clk        (clk),
    .rst        (rst),
    .load       (divLoad_c),
    .step       (divStep_c),
    .signedOp   (signedE),
    .dividend   (srcaE),
    .divisor    (srcbE),
    .quotient_c (quotient_c),
    .remainder_c(remainder_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (goE_c) begin
            if (!is_divE) begin
              {hi_o, lo_o} <= product_c;
              state        <= DONE;
            end else if (srcbE == '0) begin
              hi_o  <= srcaE;
              lo_o  <= DIVZ_LO;
              state <= DONE;
            end else begin
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (cancelE) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (lastStep_c) begin
              hi_o  <= remainder_c;
              lo_o  <= quotient_c;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 startE  input  1  mult/div instruction valid in execute stage; held high while stalled.
REQ-004 is_divE  input  1  1 = DIV/DIVU, 0 = MULT/MULTU.
REQ-005 signedE  input  1  1 = signed operation, 0 = unsigned.
REQ-006 srcaE  input  32  rs operand: dividend or multiplicand.
REQ-007 srcbE  input  32  rt operand: divisor or multiplier.
REQ-008 cancelE  input  1  abort the in-flight operation (exception/flush of the E stage).
REQ-009 stall_mdE  output  1  freeze F/D/E stages while the operation is incomplete.
REQ-010 md_doneE  output  1  one-cycle pulse; hi_o/lo_o valid; drives HI/LO write enable.
REQ-011 hi_o  output  32  product high word, or remainder.
REQ-012 lo_o  output  32  product low word, or quotient.
REQ-013 DIV_ITERS  parameter  default 32  number of divider iterations.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, DIV, DONE.
REQ-015 In IDLE, stall_mdE SHALL equal startE & ~cancelE, combinationally.
REQ-016 From IDLE, startE & ~is_divE & ~cancelE SHALL register the full 64-bit product (signed or unsigned per signedE) into {hi,lo} and go to DONE.
REQ-017 From IDLE, startE & is_divE & ~cancelE with srcbE != 0 SHALL latch |srcaE| and |srcbE| (magnitudes when signedE=1, raw values otherwise) plus the sign flags, clear the iteration counter, and go to DIV.
REQ-018 From IDLE, startE & is_divE & srcbE == 0 SHALL go directly to DONE with lo = 0xFFFFFFFF and hi = srcaE.
REQ-019 In DIV, each cycle SHALL perform one restoring radix-2 step (shift remainder/quotient, trial subtract, set quotient bit) and increment the counter.
REQ-020 In DIV, stall_mdE SHALL be 1 every cycle.
REQ-021 After DIV_ITERS steps, DIV SHALL go to DONE.
REQ-022 On leaving DIV, for signed operations the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield lo = 0x80000000, hi = 0.
REQ-024 In DONE: md_doneE = 1, stall_mdE = 0, and startE is ignored.
REQ-025 DONE SHALL always return to IDLE after one cycle.
REQ-026 Latency SHALL be: multiply, stall 1 cycle and md_doneE on cycle 1; divide, stall cycles 0..32 and md_doneE on cycle 33; divide-by-zero, md_doneE on cycle 1.
REQ-027 cancelE in DIV SHALL force IDLE on the next edge; md_doneE SHALL never pulse for that operation, and stall_mdE SHALL be 0 in that cycle.
REQ-028 cancelE in DONE SHALL suppress md_doneE in that cycle and return to IDLE.
REQ-029 startE together with cancelE in IDLE SHALL leave the state in IDLE.
REQ-030 hi_o/lo_o SHALL hold their last result until the next DONE.

Reset
REQ-031 rst SHALL force state IDLE, counter 0, hi_o = lo_o = 0, stall_mdE = 0, md_doneE = 0, and SHALL take priority over every other input.
REQ-032 rst asserted mid-divide SHALL discard the operation with no md_doneE pulse.

Structure
REQ-033 Package md_pkg SHALL hold the state enum (IDLE/DIV/DONE), DIV_ITERS, and the divide-by-zero result constants.
REQ-034 The iterative divider datapath (remainder/quotient registers, step logic, sign fix) SHALL be sub-module md_div_core; md_ctrl holds the FSM, multiply, and output registers.
REQ-035 stall_mdE SHALL be ORed into the existing stallF/stallD/stallE terms by the parent.
REQ-036 md_doneE SHALL drive the HI/LO write path that the forwarding logic observes.

Verification
REQ-037 MULTU 0xFFFFFFFF*0xFFFFFFFF -> stall 1 cycle; next cycle md_doneE=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 MULT 0xFFFFFFFE(-2)*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-039 DIV -7/2 -> 33 stall cycles, md_doneE on cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-040 DIVU 5/0 -> md_doneE on cycle 1, lo=0xFFFFFFFF, hi=5.
REQ-041 DIV started, cancelE at cycle 10 -> cycle 11 IDLE, stall 0, no md_doneE; a new DIVU 9/3 then yields lo=3, hi=0.
REQ-042 rst asserted at cycle 5 of a divide -> all outputs 0, IDLE next cycle; back-to-back MULTU then DIVU each complete exactly once.
